i2s_transmitter: RTL

//   Serialises the signed stereo sample stream from the oscillator/mixer path to an I2S DAC.
//   - Accepts one L/R sample pair per audio frame over a valid/ready handshake.
//   - Truncates each sample to WIDTH bits and shifts it out MSB first in Philips I2S format.
//   - Generates bclk and lrclk from the system clock. Sits between the voice mixer and the codec pins.
//

---
 rtl/i2s_transmitter_if.sv | 26 ++
 rtl/i2s_transmitter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/i2s_transmitter_if.sv
// Sample stream between the voice mixer and the I2S transmitter.
// The mixer drives one signed L/R pair per frame; the transmitter answers with ready.
interface i2s_transmitter_if #(
  parameter int IN_WIDTH = 32
) ();

  logic signed [IN_WIDTH-1:0] sample_l;
  logic signed [IN_WIDTH-1:0] sample_r;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: takes one stereo pair per frame from a single-entry
// holding register, truncates each sample to WIDTH bits and shifts it out MSB
// first, one bclk after each lrclk edge. bclk/lrclk are derived from clk.
// A frame that starts with nothing pending is sent as zeros and flagged.
module i2s_transmitter #(
  parameter int IN_WIDTH  = 32,
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 4
) (
  input  logic              clk,
  input  logic              rst,
  i2s_transmitter_if.slave  smp,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frame_tick,
  output logic              underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int KW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_BITS);
  localparam logic [BW-1:0] LAST_B   = BW'(FRAME_BITS - 1);

  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nxt;
  logic             div_end;
  logic             fe;
  logic             frame_load;

  logic             hold_full;
  logic [WIDTH-1:0] hold_l;
  logic [WIDTH-1:0] hold_r;
  logic [WIDTH-1:0] word_l;
  logic [WIDTH-1:0] word_r;

  logic             ch;
  logic [BW-1:0]    k_full;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] load_l;
  logic [WIDTH-1:0] load_r;
  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] shifted;
  logic             sdata_nxt;

  // Input LSBs below the truncation point and the upper slot-offset bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{smp.sample_l, smp.sample_r, k_full};

  assign smp.sample_ready = !hold_full;

  assign div_end = (div_cnt == DIV_LAST);
  assign fe      = div_end && bclk;

  // Next-bit selection: the bit driven after a falling edge belongs to the old counter position.
  always_comb begin
    bit_nxt    = (bit_cnt == LAST_B) ? '0 : bit_cnt + BW'(1);
    frame_load = fe && (bit_cnt == '0);
    ch         = (bit_cnt >= SLOT_B);
    k_full     = ch ? (bit_cnt - SLOT_B) : bit_cnt;
    k          = k_full[KW-1:0];
    load_l     = hold_full ? hold_l : '0;
    load_r     = hold_full ? hold_r : '0;
    // The left MSB leaves in the load cycle itself, so it must come from the incoming word.
    if (frame_load) begin
      cur_word = load_l;
    end else begin
      cur_word = ch ? word_r : word_l;
    end
    shifted   = cur_word << k;
    sdata_nxt = (int'(k) < WIDTH) ? shifted[WIDTH-1] : 1'b0;
  end

  // Bit clock divider: bclk toggles every BCLK_DIV clk cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      if (div_end) begin
        div_cnt <= '0;
        bclk    <= !bclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // Single-entry holding register; a frame load that drains it blocks capture for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (frame_load && hold_full) begin
      hold_full <= 1'b0;
    end else if (smp.sample_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_l    <= smp.sample_l[IN_WIDTH-1 -: WIDTH];
      hold_r    <= smp.sample_r[IN_WIDTH-1 -: WIDTH];
    end
  end

  // Frame sequencing: bit counter, word select, serial data and frame status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      word_l     <= '0;
      word_r     <= '0;
      frame_tick <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      underrun   <= 1'b0;
      if (fe) begin
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= SLOT_B);
        sdata   <= sdata_nxt;
      end
      if (frame_load) begin
        word_l     <= load_l;
        word_r     <= load_r;
        frame_tick <= 1'b1;
        underrun   <= !hold_full;
      end
    end
  end

endmodule
